dmu_ctrl: RTL and testbench

- Parametrised data-memory unit for the RISC-V core.
- Combines a word-organised data RAM with a memory-mapped pixel frame buffer.
- CPU side: request/valid handshake, configurable read latency, RV32 byte/half/word load-store modes with sign/zero extension, byte-lane write masking, and misalignment/range/mode error reporting.
- Screen side: independent read-only pixel port with one-cycle registered latency.

---
 rtl/dmu_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_dmu_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmu_ctrl.sv
// Data-memory unit: word RAM plus memory-mapped pixel frame buffer, RV32 load/store
// lane handling, configurable CPU latency, and an independent registered screen read port.
module dmu_ctrl #(
    parameter int          DM_AW    = 10,
    parameter int          SCR_AW   = 15,
    parameter int          PIX_W    = 12,
    parameter logic [31:0] SCR_BASE = 32'h0001_0000,
    parameter int          LATENCY  = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req,
    output logic              ready,
    input  logic              we,
    input  logic [2:0]        mode,
    input  logic [31:0]       dmu_addr,
    input  logic [31:0]       dmu_din,
    output logic [31:0]       dmu_dout,
    output logic              valid,
    output logic              dmu_error,
    output logic              err_sticky,
    input  logic              err_clr,
    input  logic [SCR_AW-1:0] screen_addr,
    output logic [PIX_W-1:0]  screen_data,
    output logic [1:0]        dbg_state
);

    // Handshake: a request is accepted on a rising edge where req & ready; ready is high
    // only in IDLE, and valid pulses for exactly one cycle LATENCY edges after the accept.
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

    localparam logic [32:0] RAM_END = 33'(1) << (DM_AW + 2);
    localparam logic [32:0] SCR_LO  = {1'b0, SCR_BASE};
    localparam logic [32:0] SCR_HI  = SCR_LO + (33'(1) << (SCR_AW + 2));

    logic [31:0]      mem  [0:(1 << DM_AW) - 1];
    logic [PIX_W-1:0] fbuf [0:(1 << SCR_AW) - 1];

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              err_q, we_q, sticky_q;
    logic [31:0]       res_q, dout_q;
    logic [PIX_W-1:0]  scr_q;

    logic              accept, in_ram, in_scr, bad_mode, misalign, acc_err;
    logic [DM_AW-1:0]  ram_idx;
    logic [SCR_AW-1:0] pix_idx;
    logic [31:0]       rd_word, ld_now, wdata;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [3:0]        be;
    logic [PIX_W-1:0]  pix_wdata;
    logic              ram_we, scr_we;
    logic              resp_start, resp_err, resp_we;
    logic [31:0]       resp_res;

    assign accept   = req && (state_q == IDLE);
    assign in_ram   = {1'b0, dmu_addr} < RAM_END;
    assign in_scr   = ({1'b0, dmu_addr} >= SCR_LO) && ({1'b0, dmu_addr} < SCR_HI);
    assign bad_mode = (mode == 3'b011) || (mode[2:1] == 2'b11) || (mode[2] && we);
    assign misalign = ((mode[1:0] == 2'b01) && dmu_addr[0]) ||
                      ((mode == 3'b010) && (dmu_addr[1:0] != 2'b00));
    assign acc_err  = bad_mode || misalign || !(in_ram || in_scr);
    assign ram_idx  = dmu_addr[DM_AW+1:2];
    assign pix_idx  = SCR_AW'((dmu_addr - SCR_BASE) >> 2);

    // Load path: read the word now, pick the lane, extend; latched on accept.
    assign rd_word = in_ram ? mem[ram_idx] : 32'(fbuf[pix_idx]);
    assign rd_byte = rd_word[8*dmu_addr[1:0] +: 8];
    assign rd_half = rd_word[16*dmu_addr[1] +: 16];

    always_comb begin
        ld_now = rd_word;
        case (mode)
            3'b000:  ld_now = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  ld_now = {24'b0, rd_byte};
            3'b001:  ld_now = {{16{rd_half[15]}}, rd_half};
            3'b101:  ld_now = {16'b0, rd_half};
            default: ld_now = rd_word;
        endcase
    end

    // Store path: replicate data across lanes and let the byte enables pick.
    always_comb begin
        be        = 4'b1111;
        wdata     = dmu_din;
        pix_wdata = PIX_W'(dmu_din);
        case (mode[1:0])
            2'b00: begin
                be        = 4'b0001 << dmu_addr[1:0];
                wdata     = {4{dmu_din[7:0]}};
                pix_wdata = PIX_W'({24'b0, dmu_din[7:0]});
            end
            2'b01: begin
                be        = dmu_addr[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{dmu_din[15:0]}};
                pix_wdata = PIX_W'({16'b0, dmu_din[15:0]});
            end
            default: ;
        endcase
    end

    assign ram_we = rstn && accept && we && !acc_err && in_ram;
    // Sub-word screen stores only land on the pixel's low lane; other lanes are silently dropped.
    assign scr_we = rstn && accept && we && !acc_err && in_scr &&
                    ((mode == 3'b010) || (dmu_addr[1:0] == 2'b00));

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (scr_we) fbuf[pix_idx] <= pix_wdata;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (LATENCY == 1) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 2'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) state_d = DONE;
                else               cnt_d   = cnt_q - 2'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With LATENCY=1 the response starts on the accept edge, so take the live values.
    assign resp_start = (state_d == DONE) && (state_q != DONE);
    assign resp_err   = (state_q == IDLE) ? acc_err : err_q;
    assign resp_we    = (state_q == IDLE) ? we      : we_q;
    assign resp_res   = (state_q == IDLE) ? ld_now  : res_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            res_q    <= 32'd0;
            dout_q   <= 32'd0;
            sticky_q <= 1'b0;
            scr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            scr_q   <= fbuf[screen_addr];
            if (accept) begin
                err_q <= acc_err;
                we_q  <= we;
                res_q <= ld_now;
            end
            if (resp_start) begin
                if (resp_err)     dout_q <= 32'd0;
                else if (!resp_we) dout_q <= resp_res;
            end
            if (resp_start && resp_err) sticky_q <= 1'b1;
            else if (err_clr)           sticky_q <= 1'b0;
        end
    end

    assign ready       = (state_q == IDLE);
    assign valid       = (state_q == DONE);
    assign dmu_error   = valid && err_q;
    assign dmu_dout    = dout_q;
    assign err_sticky  = sticky_q;
    assign screen_data = scr_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_dmu_ctrl.sv
// Bench for dmu_ctrl: LATENCY=1 instance checked through a response scoreboard,
// plus LATENCY=3 and LATENCY=4 instances for timing and mid-transaction reset.
module tb_dmu_ctrl;

  localparam logic [31:0] SB = 32'h0001_0000;

  logic clk = 1'b0;
  logic rstn = 1'b0, rstn4 = 1'b0;
  logic req1 = 1'b0, req3 = 1'b0, req4 = 1'b0;
  logic we_s = 1'b0, clr_s = 1'b0;
  logic [2:0] mode_s = 3'b010;
  logic [31:0] addr_s = '0, din_s = '0;
  logic [14:0] scr_a = '0;

  logic ready1, valid1, err1, stk1, ready3, valid3, err3, stk3, ready4, valid4, err4, stk4;
  logic [31:0] dout1, dout3, dout4;
  logic [11:0] scr1, scr3, scr4;
  logic [1:0] st1, st3, st4;

  int n_checks = 0;
  int n_fail = 0;
  logic [32:0] exp_q[$];
  logic [31:0] last_dout = '0;

  always #5 clk = ~clk;

  dmu_ctrl #(.LATENCY(1)) u1 (
    .clk(clk), .rstn(rstn), .req(req1), .ready(ready1), .we(we_s), .mode(mode_s),
    .dmu_addr(addr_s), .dmu_din(din_s), .dmu_dout(dout1), .valid(valid1),
    .dmu_error(err1), .err_sticky(stk1), .err_clr(clr_s), .screen_addr(scr_a),
    .screen_data(scr1), .dbg_state(st1));

  dmu_ctrl #(.LATENCY(3)) u3 (
    .clk(clk), .rstn(rstn), .req(req3), .ready(ready3), .we(we_s), .mode(mode_s),
    .dmu_addr(addr_s), .dmu_din(din_s), .dmu_dout(dout3), .valid(valid3),
    .dmu_error(err3), .err_sticky(stk3), .err_clr(clr_s), .screen_addr(scr_a),
    .screen_data(scr3), .dbg_state(st3));

  dmu_ctrl #(.LATENCY(4)) u4 (
    .clk(clk), .rstn(rstn4), .req(req4), .ready(ready4), .we(we_s), .mode(mode_s),
    .dmu_addr(addr_s), .dmu_din(din_s), .dmu_dout(dout4), .valid(valid4),
    .dmu_error(err4), .err_sticky(stk4), .err_clr(clr_s), .screen_addr(scr_a),
    .screen_data(scr4), .dbg_state(st4));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor for the LATENCY=1 instance: every valid pops one expectation.
  always @(negedge clk) begin
    if (rstn && valid1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: valid with dout %h and no expected response", dout1);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("sb_dout", dout1, e[31:0]);
        check("sb_err", 32'(err1), 32'(e[32]));
      end
    end
  end

  // One access on u1; returns at the negedge of the response cycle.
  task automatic acc1(input logic w, input logic [2:0] m, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] ed, input logic ee,
                      input logic clr);
    @(negedge clk);
    check("u1_ready_idle", 32'(ready1), 1);
    we_s = w; mode_s = m; addr_s = a; din_s = d; clr_s = clr; req1 = 1'b1;
    if (ee) begin
      exp_q.push_back({1'b1, 32'h0});
      last_dout = '0;
    end else if (w) begin
      exp_q.push_back({1'b0, last_dout});
    end else begin
      exp_q.push_back({1'b0, ed});
      last_dout = ed;
    end
    @(posedge clk);
    @(negedge clk);
    req1 = 1'b0; clr_s = 1'b0;
    check("u1_valid_next", 32'(valid1), 1);
    check("u1_ready_done", 32'(ready1), 0);
  endtask

  task automatic clr1();
    @(negedge clk);
    clr_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_s = 1'b0;
    check("u1_sticky_clr", 32'(stk1), 0);
  endtask

  task automatic acc4(input logic w, input logic [2:0] m, input logic [31:0] a,
                      input logic [31:0] d);
    @(negedge clk);
    we_s = w; mode_s = m; addr_s = a; din_s = d; req4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req4 = 1'b0;
    for (int i = 0; i < 8 && !valid4; i++) @(negedge clk);
    check("u4_valid", 32'(valid4), 1);
  endtask

  initial begin
    bit quiet;
    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready1), 1);
    check("rst_valid", 32'(valid1), 0);
    check("rst_dout", dout1, 0);
    check("rst_err", 32'(err1), 0);
    check("rst_sticky", 32'(stk1), 0);
    check("rst_screen", 32'(scr1), 0);
    rstn = 1'b1; rstn4 = 1'b1;

    // basic word store/load
    acc1(1, 3'b010, 32'h40, 32'hDEADBEEF, 0, 0, 0);
    acc1(0, 3'b010, 32'h40, 0, 32'hDEADBEEF, 0, 0);

    // lane masking and extension
    acc1(1, 3'b010, 32'h80, 32'h11223344, 0, 0, 0);
    acc1(1, 3'b000, 32'h81, 32'h000000AA, 0, 0, 0);
    acc1(1, 3'b001, 32'h82, 32'h0000BBCC, 0, 0, 0);
    acc1(0, 3'b010, 32'h80, 0, 32'hBBCCAA44, 0, 0);
    acc1(0, 3'b000, 32'h81, 0, 32'hFFFFFFAA, 0, 0);
    acc1(0, 3'b100, 32'h81, 0, 32'h000000AA, 0, 0);
    acc1(0, 3'b001, 32'h82, 0, 32'hFFFFBBCC, 0, 0);
    acc1(0, 3'b101, 32'h82, 0, 32'h0000BBCC, 0, 0);
    acc1(0, 3'b000, 32'h80, 0, 32'h00000044, 0, 0);
    acc1(0, 3'b100, 32'h83, 0, 32'h000000BB, 0, 0);

    // errors
    acc1(0, 3'b001, 32'h41, 0, 0, 1, 0);
    check("u1_sticky_set", 32'(stk1), 1);
    acc1(0, 3'b010, 32'h40, 0, 32'hDEADBEEF, 0, 0);
    acc1(0, 3'b011, 32'h40, 0, 0, 1, 0);
    acc1(1, 3'b100, 32'h40, 32'h55, 0, 1, 0);
    acc1(0, 3'b010, 32'h8000_0000, 0, 0, 1, 0);
    acc1(1, 3'b010, 32'h42, 32'h12345678, 0, 1, 0);
    acc1(0, 3'b010, 32'h40, 0, 32'hDEADBEEF, 0, 0);
    acc1(1, 3'b010, 32'hFFC, 32'h0F0F0F0F, 0, 0, 0);
    acc1(0, 3'b010, 32'hFFC, 0, 32'h0F0F0F0F, 0, 0);
    acc1(0, 3'b010, 32'h1000, 0, 0, 1, 0);
    acc1(1, 3'b010, 32'h0000FFFC, 32'h1, 0, 1, 0);
    acc1(1, 3'b010, SB + 32'h1FFFC, 32'h000007FF, 0, 0, 0);
    acc1(0, 3'b010, SB + 32'h1FFFC, 0, 32'h000007FF, 0, 0);
    acc1(0, 3'b010, SB + 32'h20000, 0, 0, 1, 0);
    check("u1_sticky_hold", 32'(stk1), 1);
    clr1();
    acc1(0, 3'b111, 32'h40, 0, 0, 1, 1);
    check("u1_sticky_setwins", 32'(stk1), 1);
    clr1();

    // screen port
    acc1(1, 3'b010, SB + 32'h8, 32'h00000ABC, 0, 0, 0);
    scr_a = 15'd2;
    @(posedge clk);
    @(negedge clk);
    check("scr_pix2", 32'(scr1), 32'hABC);
    acc1(1, 3'b000, SB + 32'h9, 32'h00000055, 0, 0, 0);
    @(negedge clk);
    check("scr_pix2_sb_ignored", 32'(scr1), 32'hABC);
    acc1(0, 3'b010, SB + 32'h8, 0, 32'h00000ABC, 0, 0);
    acc1(0, 3'b000, SB + 32'h9, 0, 32'h0000000A, 0, 0);
    scr_a = 15'd3;
    acc1(1, 3'b010, SB + 32'hC, 32'h00000111, 0, 0, 0);
    acc1(1, 3'b001, SB + 32'hC, 32'h0000F222, 0, 0, 0);
    check("scr_same_edge_old", 32'(scr1), 32'h111);
    @(posedge clk);
    @(negedge clk);
    check("scr_sh_trunc", 32'(scr1), 32'h222);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);

    // LATENCY=3 timing
    @(negedge clk);
    we_s = 1'b1; mode_s = 3'b010; addr_s = 32'h10; din_s = 32'h00001234; req3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("l3_t0_valid", 32'(valid3), 0);
    check("l3_t0_ready", 32'(ready3), 0);
    @(negedge clk);
    check("l3_t1_valid", 32'(valid3), 0);
    @(negedge clk);
    check("l3_t2_valid", 32'(valid3), 1);
    check("l3_t2_ready", 32'(ready3), 0);
    we_s = 1'b0;
    @(negedge clk);
    check("l3_t3_ready", 32'(ready3), 1);
    check("l3_t3_valid", 32'(valid3), 0);
    @(negedge clk);
    check("l3_reaccept", 32'(ready3), 0);
    req3 = 1'b0;
    @(negedge clk);
    req3 = 1'b1;
    @(negedge clk);
    req3 = 1'b0;
    check("l3_load_valid", 32'(valid3), 1);
    check("l3_load_dout", dout3, 32'h00001234);
    @(negedge clk);
    check("l3_pulse_ign_a", {31'b0, ready3} | {30'b0, valid3, 1'b0}, 1);
    @(negedge clk);
    check("l3_pulse_ign_b", {31'b0, ready3} | {30'b0, valid3, 1'b0}, 1);

    // LATENCY=4 with reset mid-transaction
    acc4(1, 3'b010, 32'h20, 32'hCAFEF00D);
    acc4(0, 3'b011, 32'h20, 0);
    check("u4_err", 32'(err4), 1);
    acc4(0, 3'b010, 32'h20, 0);
    check("u4_dout_pre", dout4, 32'hCAFEF00D);
    check("u4_sticky_pre", 32'(stk4), 1);
    @(negedge clk);
    we_s = 1'b0; mode_s = 3'b010; addr_s = 32'h20; req4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req4 = 1'b0; rstn4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn4 = 1'b1;
    check("u4_rst_ready", 32'(ready4), 1);
    check("u4_rst_sticky", 32'(stk4), 0);
    check("u4_rst_dout", dout4, 0);
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (valid4) quiet = 1'b0;
      @(negedge clk);
    end
    check("u4_no_valid", 32'(quiet), 1);
    acc4(0, 3'b010, 32'h20, 0);
    check("u4_ram_kept", dout4, 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded %0d ns", 200000);
    $fatal(1, "timeout");
  end

endmodule
